// File: rtl/bus_arbiter_if.sv
// Requester-side handshake for the two-port peripheral bus arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              grant;

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1, busy, grant
  );

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1, busy, grant
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port arbiter that turns each access into a timed setup/strobe/hold bus cycle.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking (default: port 0 wins ties).
//
// state  | meaning
// IDLE   | bus parked, sampling req0/req1
// SETUP  | address (and write data) driven, strobes high
// STROBE | read_n or write_n low
// HOLD   | strobes high, ack to granted port
module bus_arbiter #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              read_n,
  output logic              write_n
);

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              data_oe;
  logic              pick1;

  always_comb begin
    pick1 = 1'b0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    // on a tie, the port that was not granted last goes next
    pick1 = bus.req1 & (~bus.req0 | ~bus.grant);
`else
    pick1 = bus.req1 & ~bus.req0;
`endif
  end

  assign data_bus = data_oe ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rw_q        <= 1'b1;
      wdata_q     <= '0;
      data_oe     <= 1'b0;
      address_bus <= '0;
      read_n      <= 1'b1;
      write_n     <= 1'b1;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.rdata0  <= '0;
      bus.rdata1  <= '0;
      bus.busy    <= 1'b0;
      bus.grant   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            bus.grant   <= pick1;
            address_bus <= pick1 ? bus.addr1 : bus.addr0;
            rw_q        <= pick1 ? bus.rw1 : bus.rw0;
            wdata_q     <= pick1 ? bus.wdata1 : bus.wdata0;
            data_oe     <= pick1 ? ~bus.rw1 : ~bus.rw0;
            cnt         <= SETUP_LOAD;
            bus.busy    <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            cnt     <= STROBE_LOAD;
            read_n  <= ~rw_q;
            write_n <= rw_q;
            state   <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            read_n  <= 1'b1;
            write_n <= 1'b1;
            if (rw_q) begin
              if (bus.grant) bus.rdata1 <= data_bus;
              else           bus.rdata0 <= data_bus;
            end
            if (bus.grant) bus.ack1 <= 1'b1;
            else           bus.ack0 <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.busy <= 1'b0;
          data_oe  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
